// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC control blocks: state encoding, CSR table entry layout
// and the default 10G MAC bring-up table.
package mac_ctrl_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_UP        = 3'd3;
    localparam logic [2:0] ST_ERR       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_LOCK = ST_WAIT_LOCK,
        S_WRITE     = ST_WRITE,
        S_UP        = ST_UP,
        S_ERR       = ST_ERR
    } seq_state_t;

    // Entry 0 sits in the low bits and is written first.
    localparam int MAC_INIT_NUM = 4;
    localparam logic [MAC_INIT_NUM*ENTRY_W-1:0] MAC_INIT_TBL_10G = {
        {10'h008, 32'h0000_FFFF},  // pause quanta
        {10'h014, 32'h0000_0001},  // rx CRC strip
        {10'h00C, 32'h0000_05EE},  // max frame length 1518
        {10'h004, 32'h0000_0003}   // tx/rx path enable
    };

    function automatic logic [ADDR_W-1:0] entry_addr(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1 -: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mac_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module mac_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mac_link_init_seq.sv
// Link bring-up sequencer: waits for stable PHY ready + block lock, replays a CSR write table
// over Avalon-MM, then reports link up and re-arms on lock loss.
//
// state     | meaning
// IDLE      | disabled, outputs idle
// WAIT_LOCK | counting stable lock cycles
// WRITE     | issuing table entry idx
// UP        | table written, watching lock
// ERR       | write timed out, waits for enable=0
module mac_link_init_seq
    import mac_ctrl_pkg::*;
#(
    parameter int                          NUM_WR      = 4,
    parameter logic [NUM_WR*ENTRY_W-1:0]   INIT_TBL    = {NUM_WR{42'h0}},
    parameter int                          STABLE_CYC  = 1024,
    parameter int                          TIMEOUT_CYC = 255
) (
    input  logic              csr_clk,
    input  logic              csr_rst_n,
    input  logic              enable,
    input  logic              phy_ready,
    input  logic              block_lock,
    output logic              mac_csr_write,
    output logic              mac_csr_read,
    output logic [ADDR_W-1:0] mac_csr_address,
    output logic [DATA_W-1:0] mac_csr_writedata,
    input  logic              mac_csr_waitrequest,
    output logic              link_up,
    output logic              init_err,
    output logic [7:0]        restart_cnt,
    output logic [2:0]        state_o
);

    localparam int IDX_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int STAB_W = $clog2(STABLE_CYC);
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    seq_state_t          state;
    logic                phy_ready_s;
    logic                block_lock_s;
    logic                lock_s;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_inc;
    logic                idx_last;
    logic [ENTRY_W-1:0]  entry_first;
    logic [ENTRY_W-1:0]  entry_nxt;

    mac_sync2 u_sync_phy (
        .clk   (csr_clk),
        .rst_n (csr_rst_n),
        .d     (phy_ready),
        .q     (phy_ready_s)
    );

    mac_sync2 u_sync_lock (
        .clk   (csr_clk),
        .rst_n (csr_rst_n),
        .d     (block_lock),
        .q     (block_lock_s)
    );

    assign lock_s       = phy_ready_s & block_lock_s;
    assign idx_inc      = idx + 1'b1;
    assign idx_last     = (idx == IDX_W'(NUM_WR - 1));
    assign entry_first  = INIT_TBL[ENTRY_W-1:0];
    assign entry_nxt    = INIT_TBL[idx_inc*ENTRY_W +: ENTRY_W];
    assign mac_csr_read = 1'b0;
    assign state_o      = state;

    always_ff @(posedge csr_clk or negedge csr_rst_n) begin
        if (!csr_rst_n) begin
            state             <= S_IDLE;
            stab_cnt          <= '0;
            to_cnt            <= '0;
            idx               <= '0;
            mac_csr_write     <= 1'b0;
            mac_csr_address   <= '0;
            mac_csr_writedata <= '0;
            link_up           <= 1'b0;
            init_err          <= 1'b0;
            restart_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    link_up <= 1'b0;
                    if (enable) begin
                        stab_cnt <= '0;
                        state    <= S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (!enable) begin
                        link_up <= 1'b0;
                        state   <= S_IDLE;
                    end else if (!lock_s) begin
                        stab_cnt <= '0;
                    end else if (stab_cnt == STAB_W'(STABLE_CYC - 1)) begin
                        stab_cnt          <= '0;
                        idx               <= '0;
                        to_cnt            <= '0;
                        init_err          <= 1'b0;
                        mac_csr_write     <= 1'b1;
                        mac_csr_address   <= entry_addr(entry_first);
                        mac_csr_writedata <= entry_data(entry_first);
                        state             <= S_WRITE;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    // A pending write is never withdrawn except by timeout.
                    if (!mac_csr_waitrequest) begin
                        to_cnt <= '0;
                        if (idx_last || !enable) begin
                            mac_csr_write     <= 1'b0;
                            mac_csr_address   <= '0;
                            mac_csr_writedata <= '0;
                            if (enable) begin
                                link_up <= 1'b1;
                                state   <= S_UP;
                            end else begin
                                state   <= S_IDLE;
                            end
                        end else begin
                            idx               <= idx_inc;
                            mac_csr_address   <= entry_addr(entry_nxt);
                            mac_csr_writedata <= entry_data(entry_nxt);
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        to_cnt            <= '0;
                        mac_csr_write     <= 1'b0;
                        mac_csr_address   <= '0;
                        mac_csr_writedata <= '0;
                        init_err          <= 1'b1;
                        state             <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_UP: begin
                    if (!enable) begin
                        link_up <= 1'b0;
                        state   <= S_IDLE;
                    end else if (!lock_s) begin
                        link_up  <= 1'b0;
                        stab_cnt <= '0;
                        if (restart_cnt != 8'hFF) restart_cnt <= restart_cnt + 8'd1;
                        state    <= S_WAIT_LOCK;
                    end
                end
                S_ERR: begin
                    if (!enable) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_link_init_seq.sv
// Bench for mac_link_init_seq: directed lock/enable/waitrequest sequences, CSR writes checked
// by a queue-based scoreboard monitor.
module tb_mac_link_init_seq;

    localparam logic [41:0] E0 = {10'h010, 32'h0000_0003};
    localparam logic [41:0] E1 = {10'h014, 32'h0000_05EE};
    localparam logic [41:0] E2 = {10'h018, 32'h0000_0001};
    localparam logic [41:0] E3 = {10'h01C, 32'h0000_FFFF};
    localparam logic [4*42-1:0] TBL = {E3, E2, E1, E0};

    logic        csr_clk = 1'b0;
    logic        csr_rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        phy_ready = 1'b0;
    logic        block_lock = 1'b0;
    logic        mac_csr_waitrequest = 1'b0;
    logic        mac_csr_write;
    logic        mac_csr_read;
    logic [9:0]  mac_csr_address;
    logic [31:0] mac_csr_writedata;
    logic        link_up;
    logic        init_err;
    logic [7:0]  restart_cnt;
    logic [2:0]  state_o;

    int          total = 0;
    int          bad = 0;
    int          compl_cnt = 0;
    logic [41:0] sb_q[$];
    logic        prev_stall = 1'b0;
    logic [41:0] prev_ad = '0;
    logic [41:0] mon_exp;
    int          exp_rc = 0;
    int          n;
    int          c0;

    always #5 csr_clk = ~csr_clk;

    mac_link_init_seq #(
        .NUM_WR      (4),
        .INIT_TBL    (TBL),
        .STABLE_CYC  (16),
        .TIMEOUT_CYC (255)
    ) dut (
        .csr_clk             (csr_clk),
        .csr_rst_n           (csr_rst_n),
        .enable              (enable),
        .phy_ready           (phy_ready),
        .block_lock          (block_lock),
        .mac_csr_write       (mac_csr_write),
        .mac_csr_read        (mac_csr_read),
        .mac_csr_address     (mac_csr_address),
        .mac_csr_writedata   (mac_csr_writedata),
        .mac_csr_waitrequest (mac_csr_waitrequest),
        .link_up             (link_up),
        .init_err            (init_err),
        .restart_cnt         (restart_cnt),
        .state_o             (state_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge csr_clk);
        #1;
    endtask

    task automatic push_table();
        sb_q.push_back(E0);
        sb_q.push_back(E1);
        sb_q.push_back(E2);
        sb_q.push_back(E3);
    endtask

    task automatic wait_write(output int cyc);
        cyc = 0;
        while (!mac_csr_write && cyc < 100) begin
            @(posedge csr_clk);
            #1;
            cyc++;
        end
        check("write_seen", mac_csr_write, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_write", mac_csr_write, 1'b0);
        check("rst_read", mac_csr_read, 1'b0);
        check("rst_addr", mac_csr_address, 10'h0);
        check("rst_data", mac_csr_writedata, 32'h0);
        check("rst_link_up", link_up, 1'b0);
        check("rst_init_err", init_err, 1'b0);
        check("rst_restart_cnt", restart_cnt, 8'h0);
        check("rst_state", state_o, 3'd0);
    endtask

    // Monitor: pops one expected entry per completed write and checks hold/idle rules.
    always @(negedge csr_clk) begin
        if (!csr_rst_n) begin
            prev_stall = 1'b0;
        end else if (mac_csr_write) begin
            if (prev_stall)
                check("hold_addr_data", {mac_csr_address, mac_csr_writedata}, prev_ad);
            if (!mac_csr_waitrequest) begin
                compl_cnt++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%h required=none",
                             {mac_csr_address, mac_csr_writedata});
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("write_addr_data", {mac_csr_address, mac_csr_writedata}, mon_exp);
                end
            end
            prev_stall = mac_csr_waitrequest;
            prev_ad    = {mac_csr_address, mac_csr_writedata};
        end else begin
            prev_stall = 1'b0;
            check("idle_addr_data_zero", {mac_csr_address, mac_csr_writedata}, 42'h0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_reset_outputs();
        csr_rst_n = 1'b1;
        tick(2);

        // basic bring-up with first-write latency
        enable = 1'b1; phy_ready = 1'b1; block_lock = 1'b1;
        push_table();
        wait_write(n);
        check("first_write_latency", n, 18);
        check("state_write", state_o, 3'd2);
        tick(3);
        check("last_write_active", mac_csr_write, 1'b1);
        check("link_up_not_yet", link_up, 1'b0);
        tick(1);
        check("link_up_after_table", link_up, 1'b1);
        check("write_dropped", mac_csr_write, 1'b0);
        check("state_up", state_o, 3'd3);
        check("sb_empty_a", sb_q.size(), 0);

        // lock loss in UP and replay
        block_lock = 1'b0;
        tick(3);
        exp_rc = 1;
        check("lock_loss_link_down", link_up, 1'b0);
        check("restart_cnt_1", restart_cnt, exp_rc);
        check("state_wait_lock", state_o, 3'd1);
        block_lock = 1'b1;
        push_table();
        wait_write(n);
        check("replay_latency", n, 18);
        tick(4);
        check("replay_link_up", link_up, 1'b1);
        check("sb_empty_b", sb_q.size(), 0);

        // lock glitch restarts the stability count
        enable = 1'b0; phy_ready = 1'b0; block_lock = 1'b0;
        tick(1);
        check("disable_to_idle", state_o, 3'd0);
        check("disable_link_down", link_up, 1'b0);
        tick(2);
        enable = 1'b1; phy_ready = 1'b1; block_lock = 1'b1;
        push_table();
        tick(12);
        check("no_early_write", mac_csr_write, 1'b0);
        block_lock = 1'b0;
        tick(1);
        block_lock = 1'b1;
        wait_write(n);
        check("write_after_glitch", n, 18);
        tick(4);
        check("glitch_link_up", link_up, 1'b1);

        // waitrequest stall on entry 1
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        push_table();
        c0 = compl_cnt;
        wait_write(n);
        check("latency_lock_already_stable", n, 17);
        tick(1);
        mac_csr_waitrequest = 1'b1;
        tick(3);
        check("stall_write_held", mac_csr_write, 1'b1);
        check("stall_state_write", state_o, 3'd2);
        check("stall_addr_e1", mac_csr_address, E1[41:32]);
        mac_csr_waitrequest = 1'b0;
        tick(3);
        check("stall_link_up", link_up, 1'b1);
        check("stall_completions", compl_cnt - c0, 4);
        check("sb_empty_d", sb_q.size(), 0);

        // write timeout
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        push_table();
        wait_write(n);
        tick(1);
        mac_csr_waitrequest = 1'b1;
        tick(254);
        check("to_still_writing", mac_csr_write, 1'b1);
        check("to_no_err_yet", init_err, 1'b0);
        tick(1);
        check("to_write_dropped", mac_csr_write, 1'b0);
        check("to_init_err", init_err, 1'b1);
        check("to_state_err", state_o, 3'd4);
        sb_q.delete();
        mac_csr_waitrequest = 1'b0;
        tick(3);
        check("err_holds", state_o, 3'd4);
        enable = 1'b0;
        tick(1);
        check("err_to_idle", state_o, 3'd0);
        check("err_sticky", init_err, 1'b1);
        enable = 1'b1;
        push_table();
        wait_write(n);
        check("err_cleared_on_write", init_err, 1'b0);
        tick(4);
        check("after_err_link_up", link_up, 1'b1);

        // disable during a stalled write
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        mac_csr_waitrequest = 1'b1;
        sb_q.push_back(E0);
        wait_write(n);
        enable = 1'b0;
        tick(3);
        check("dis_write_held", mac_csr_write, 1'b1);
        check("dis_state_write", state_o, 3'd2);
        mac_csr_waitrequest = 1'b0;
        tick(1);
        check("dis_write_done", mac_csr_write, 1'b0);
        check("dis_state_idle", state_o, 3'd0);
        tick(4);
        check("dis_no_next_entry", mac_csr_write, 1'b0);
        check("sb_empty_f", sb_q.size(), 0);

        // restart_cnt saturation
        enable = 1'b1;
        push_table();
        wait_write(n);
        tick(4);
        check("sat_start_link_up", link_up, 1'b1);
        for (int r = 0; r < 299; r++) begin
            block_lock = 1'b0;
            tick(3);
            exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
            check("restart_cnt_model", restart_cnt, exp_rc);
            block_lock = 1'b1;
            push_table();
            wait_write(n);
            tick(4);
        end
        check("restart_cnt_saturated", restart_cnt, 8'd255);
        check("sat_end_link_up", link_up, 1'b1);

        // reset during a stalled write
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        push_table();
        wait_write(n);
        tick(1);
        mac_csr_waitrequest = 1'b1;
        tick(2);
        csr_rst_n = 1'b0;
        tick(1);
        check_reset_outputs();
        sb_q.delete();
        mac_csr_waitrequest = 1'b0;
        csr_rst_n = 1'b1;
        push_table();
        wait_write(n);
        check("post_reset_latency", n, 18);
        tick(4);
        check("post_reset_link_up", link_up, 1'b1);
        check("post_reset_restart_cnt", restart_cnt, 8'd0);
        check("sb_empty_end", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
